// File: rtl/prism_sp_unit_puzzle_mc.sv
// Multi-channel SP puzzle-FIFO access unit: empty/full queries, pop/push with optional
// blocking and timeout, and 64-bit words returned as two 32-bit result reads.
module prism_sp_unit_puzzle_mc #(
   parameter int NFIFOS     = 4,
   parameter int FIFO_WIDTH = 32,
   parameter int TIMEOUT    = 1023,
   parameter int CH_W       = ($clog2(NFIFOS) > 0) ? $clog2(NFIFOS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   output logic                         issue_ready,
   input  logic [2:0]                   issue_op,
   input  logic                         issue_block,
   input  logic [3:0]                   issue_ch,
   input  logic [31:0]                  rs1,
   input  logic [31:0]                  rs2,
   output logic                         done,
   output logic                         done_err,
   output logic [31:0]                  result,
   input  logic [NFIFOS-1:0]            fifo_r_empty,
   input  logic [NFIFOS*FIFO_WIDTH-1:0] fifo_r_rd_data,
   output logic [NFIFOS-1:0]            fifo_r_rd_en,
   input  logic [NFIFOS-1:0]            fifo_w_full,
   output logic [NFIFOS-1:0]            fifo_w_wr_en,
   output logic [FIFO_WIDTH-1:0]        fifo_w_wr_data
);

   localparam int NPAD  = 1 << CH_W;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   localparam logic [2:0] OP_R_EMPTY  = 3'd0;
   localparam logic [2:0] OP_R_POP    = 3'd1;
   localparam logic [2:0] OP_R_POP_HI = 3'd2;
   localparam logic [2:0] OP_W_FULL   = 3'd3;
   localparam logic [2:0] OP_W_PUSH   = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_op;
   logic [CH_W-1:0]   r_ch;
   logic              r_ch_ok;
   logic              r_block;
   logic [31:0]       r_rs1;
   logic [31:0]       r_rs2;
   logic [31:0]       r_hi;
   logic [31:0]       r_result;
   logic [CNT_W-1:0]  r_wait_cnt;

   logic                  w_accept;
   logic [FIFO_WIDTH-1:0] w_words [NPAD];
   logic [NPAD-1:0]       w_empty_pad;
   logic [NPAD-1:0]       w_full_pad;
   logic [FIFO_WIDTH-1:0] w_sel_word;
   logic [31:0]           w_sel_hi;
   logic                  w_sel_empty;
   logic                  w_sel_full;
   logic                  w_flag_clear;
   logic                  w_done;
   logic                  w_err;
   logic [31:0]           w_res;
   logic                  w_rd_fire;
   logic                  w_wr_fire;
   logic                  w_hi_load;

   // Pad the channel view to a power of two; phantom channels read as empty and full.
   generate
      for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
         if (gi < NFIFOS) begin : g_real
            assign w_words[gi]     = fifo_r_rd_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
            assign w_empty_pad[gi] = fifo_r_empty[gi];
            assign w_full_pad[gi]  = fifo_w_full[gi];
         end else begin : g_phantom
            assign w_words[gi]     = '0;
            assign w_empty_pad[gi] = 1'b1;
            assign w_full_pad[gi]  = 1'b1;
         end
      end

      if (FIFO_WIDTH == 64) begin : g_w64
         assign w_sel_hi       = w_sel_word[63:32];
         assign fifo_w_wr_data = {r_rs2, r_rs1};
      end else if (FIFO_WIDTH == 32) begin : g_w32
         logic w_unused_hi;
         assign w_unused_hi    = ^r_rs2;
         assign w_sel_hi       = '0;
         assign fifo_w_wr_data = r_rs1;
      end else begin : g_bad_width
         $error("prism_sp_unit_puzzle_mc: FIFO_WIDTH must be 32 or 64");
      end

      for (genvar gi = 0; gi < NFIFOS; gi++) begin : g_strobe
         assign fifo_r_rd_en[gi] = w_rd_fire && (r_ch == CH_W'(gi));
         assign fifo_w_wr_en[gi] = w_wr_fire && (r_ch == CH_W'(gi));
      end
   endgenerate

   assign w_accept     = issue_valid && (r_state == S_IDLE);
   assign w_sel_word   = w_words[r_ch];
   assign w_sel_empty  = r_ch_ok ? w_empty_pad[r_ch] : 1'b1;
   assign w_sel_full   = r_ch_ok ? w_full_pad[r_ch]  : 1'b1;
   assign w_flag_clear = (r_op == OP_R_POP) ? !w_sel_empty : !w_sel_full;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (issue_valid) w_state_next = S_EXEC;
         S_EXEC:  w_state_next = w_done ? S_IDLE : S_WAIT;
         S_WAIT:  if (w_done) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Everything is suppressed while rst is high so a waiting op cannot complete in the reset cycle.
   always_comb begin
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_res     = '0;
      w_rd_fire = 1'b0;
      w_wr_fire = 1'b0;
      w_hi_load = 1'b0;
      if (!rst) begin
         case (r_state)
            S_EXEC: begin
               case (r_op)
                  OP_R_EMPTY: begin
                     w_done = 1'b1;
                     w_res  = {31'b0, w_sel_empty};
                  end
                  OP_W_FULL: begin
                     w_done = 1'b1;
                     w_res  = {31'b0, w_sel_full};
                  end
                  OP_R_POP_HI: begin
                     w_done = 1'b1;
                     w_res  = r_hi;
                  end
                  OP_R_POP: begin
                     if (!r_ch_ok) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                     end else if (!w_sel_empty) begin
                        w_done    = 1'b1;
                        w_rd_fire = 1'b1;
                        w_hi_load = 1'b1;
                        w_res     = w_sel_word[31:0];
                     end else if (!r_block) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                     end
                  end
                  OP_W_PUSH: begin
                     if (!r_ch_ok) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                     end else if (!w_sel_full) begin
                        w_done    = 1'b1;
                        w_wr_fire = 1'b1;
                     end else if (!r_block) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                     end
                  end
                  default: begin
                     w_done = 1'b1;
                     w_err  = 1'b1;
                  end
               endcase
            end
            S_WAIT: begin
               if (w_flag_clear) begin
                  w_done = 1'b1;
                  if (r_op == OP_R_POP) begin
                     w_rd_fire = 1'b1;
                     w_hi_load = 1'b1;
                     w_res     = w_sel_word[31:0];
                  end else begin
                     w_wr_fire = 1'b1;
                  end
               end else if ((TIMEOUT != 0) && (r_wait_cnt == CNT_LAST)) begin
                  w_done = 1'b1;
                  w_err  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op       <= '0;
         r_ch       <= '0;
         r_ch_ok    <= 1'b0;
         r_block    <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_hi       <= '0;
         r_result   <= '0;
         r_wait_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= issue_op;
            r_ch    <= issue_ch[CH_W-1:0];
            r_ch_ok <= ({1'b0, issue_ch} < 5'(NFIFOS));
            r_block <= issue_block;
            r_rs1   <= rs1;
            r_rs2   <= rs2;
         end
         if ((r_state != S_WAIT) || w_done || (TIMEOUT == 0)) r_wait_cnt <= '0;
         else                                                 r_wait_cnt <= r_wait_cnt + 1'b1;
         if (w_hi_load) r_hi     <= w_sel_hi;
         if (w_done)    r_result <= w_res;
      end
   end

   assign issue_ready = (r_state == S_IDLE);
   assign done        = w_done;
   assign done_err    = w_err;
   assign result      = w_done ? w_res : r_result;

endmodule
